// File: rtl/strand_select_pkg.sv
// Shared strand definitions for the issue-side pipeline and its neighbours.
// Holds strand sizing, strand typedefs and the control-register index map.
package strand_select_pkg;

    localparam int STRAND_COUNT = 4;
    localparam int STRAND_ID_W  = 2;

    typedef logic [STRAND_ID_W-1:0]  strand_id_t;
    typedef logic [STRAND_COUNT-1:0] strand_mask_t;

    // Control-register indices shared with the control register block.
    localparam int STRAND_STATUS_CR = 29;
    localparam int STRAND_ENABLE_CR = 30;
    localparam int STRAND_ID_CR     = 31;

    function automatic strand_mask_t strand_onehot(input strand_id_t id);
        return strand_mask_t'(1) << id;
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Four-request rotating-priority arbiter: the request just after `pointer`
// has highest priority, the pointer's own request has lowest.
module rr_arbiter4
    import strand_select_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] pointer,
    output logic [3:0] grant,
    output logic [1:0] grant_id,
    output logic       grant_valid
);

    logic [1:0] idx;

    always_comb begin
        grant_valid = 1'b0;
        grant_id    = pointer;
        idx         = pointer;
        for (int k = 1; k <= 4; k++) begin
            idx = 2'(pointer + k);
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant_id    = idx;
            end
        end
        grant = grant_valid ? strand_onehot(grant_id) : 4'b0000;
    end

endmodule

// File: rtl/strand_select_stage.sv
// Issue-side strand arbiter: picks one eligible strand per cycle round-robin,
// skipping suspended and latency-blocked strands, into a registered issue slot.
module strand_select_stage
    import strand_select_pkg::*;
#(
    parameter int LONG_LATENCY_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] strand_enable,
    input  logic [3:0] if_instruction_valid,
    input  logic [3:0] if_long_latency,
    input  logic [3:0] suspend_strand,
    input  logic [3:0] resume_strand,
    input  logic [3:0] rollback_strand,
    input  logic       execute_hazard,
    output logic [3:0] ss_strand_grant,
    output logic [1:0] ss_strand,
    output logic       ss_instruction_valid,
    output logic [3:0] ss_strand_blocked
);

    localparam logic [2:0] WAIT_LOAD = 3'(LONG_LATENCY_CYCLES - 1);

    logic [1:0] pointer;
    logic [3:0] suspended;
    logic [2:0] wait_count [STRAND_COUNT];
    logic [2:0] wait_next  [STRAND_COUNT];
    logic [3:0] susp_next;
    logic [3:0] blocked_next;
    logic [3:0] eligible;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       grant_valid;

    assign req             = execute_hazard ? 4'b0000 : eligible;
    assign ss_strand_grant = grant;

    rr_arbiter4 u_arbiter (
        .req         (req),
        .pointer     (pointer),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    for (genvar i = 0; i < STRAND_COUNT; i++) begin : g_strand
        assign eligible[i] = strand_enable[i] & if_instruction_valid[i] & ~suspended[i]
                           & (wait_count[i] == 3'd0) & ~rollback_strand[i];

        // Rollback discards the blocking instruction, so its latency window goes too.
        assign wait_next[i] = rollback_strand[i]                ? 3'd0 :
                              (grant[i] & if_long_latency[i])   ? WAIT_LOAD :
                              (wait_count[i] != 3'd0)           ? wait_count[i] - 3'd1 :
                                                                  3'd0;

        assign susp_next[i]    = suspend_strand[i] | (suspended[i] & ~resume_strand[i]);
        assign blocked_next[i] = susp_next[i] | (wait_next[i] != 3'd0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            suspended         <= 4'b0000;
            ss_strand_blocked <= 4'b0000;
            for (int i = 0; i < STRAND_COUNT; i++) wait_count[i] <= 3'd0;
        end else begin
            suspended         <= susp_next;
            ss_strand_blocked <= blocked_next;
            for (int i = 0; i < STRAND_COUNT; i++) wait_count[i] <= wait_next[i];
        end
    end

    // A squash of the held instruction beats the hazard hold; a fresh grant beats both.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ss_strand            <= 2'd0;
            ss_instruction_valid <= 1'b0;
            pointer              <= 2'd3;
        end else if (grant_valid) begin
            ss_strand            <= grant_id;
            ss_instruction_valid <= 1'b1;
            pointer              <= grant_id;
        end else if (!execute_hazard ||
                     (ss_instruction_valid && rollback_strand[ss_strand])) begin
            ss_instruction_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_strand_select_stage.sv
// Bench for strand_select_stage: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_strand_select_stage;

    localparam int L = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] strand_enable = '0;
    logic [3:0] if_instruction_valid = '0;
    logic [3:0] if_long_latency = '0;
    logic [3:0] suspend_strand = '0;
    logic [3:0] resume_strand = '0;
    logic [3:0] rollback_strand = '0;
    logic       execute_hazard = 1'b0;
    logic [3:0] ss_strand_grant;
    logic [1:0] ss_strand;
    logic       ss_instruction_valid;
    logic [3:0] ss_strand_blocked;

    int checks = 0;
    int errors = 0;

    // Model: a strand is latency-blocked until an absolute cycle number.
    bit m_susp[4];
    int m_ready[4];
    int m_ptr;
    bit m_valid;
    int m_strand;
    int cyc = 0;

    logic [3:0] exp_q[$];

    strand_select_stage #(.LONG_LATENCY_CYCLES(L)) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .strand_enable        (strand_enable),
        .if_instruction_valid (if_instruction_valid),
        .if_long_latency      (if_long_latency),
        .suspend_strand       (suspend_strand),
        .resume_strand        (resume_strand),
        .rollback_strand      (rollback_strand),
        .execute_hazard       (execute_hazard),
        .ss_strand_grant      (ss_strand_grant),
        .ss_strand            (ss_strand),
        .ss_instruction_valid (ss_instruction_valid),
        .ss_strand_blocked    (ss_strand_blocked)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_ptr    = 3;
        m_valid  = 0;
        m_strand = 0;
        for (int i = 0; i < 4; i++) begin
            m_susp[i]  = 0;
            m_ready[i] = 0;
        end
    endtask

    task automatic drive_idle();
        strand_enable        = '0;
        if_instruction_valid = '0;
        if_long_latency      = '0;
        suspend_strand       = '0;
        resume_strand        = '0;
        rollback_strand      = '0;
        execute_hazard       = 1'b0;
    endtask

    // One cycle: check registered outputs, apply inputs, check grant, advance model.
    task automatic step(input logic [3:0] en, input logic [3:0] vld, input logic [3:0] ll,
                        input logic [3:0] sus, input logic [3:0] res, input logic [3:0] rb,
                        input logic hz);
        logic [3:0] exp_blk;
        logic [3:0] exp_grant;
        bit         found;
        int         gid;
        @(negedge clk);
        for (int i = 0; i < 4; i++) exp_blk[i] = m_susp[i] || (cyc < m_ready[i]);
        check("issue_valid", ss_instruction_valid, m_valid);
        check("issue_strand", ss_strand, m_strand[1:0]);
        check("blocked", ss_strand_blocked, exp_blk);
        strand_enable        = en;
        if_instruction_valid = vld;
        if_long_latency      = ll;
        suspend_strand       = sus;
        resume_strand        = res;
        rollback_strand      = rb;
        execute_hazard       = hz;
        #1;
        found = 0;
        gid   = 0;
        if (!hz) begin
            for (int k = 1; k <= 4; k++) begin
                int s;
                s = (m_ptr + k) % 4;
                if (!found && en[s] && vld[s] && !m_susp[s] && cyc >= m_ready[s] && !rb[s]) begin
                    found = 1;
                    gid   = s;
                end
            end
        end
        exp_grant = found ? 4'(1 << gid) : 4'd0;
        check("grant", ss_strand_grant, exp_grant);
        if (m_valid && rb[m_strand]) m_valid = 0;
        if (found) begin
            m_valid  = 1;
            m_strand = gid;
            m_ptr    = gid;
            if (ll[gid]) m_ready[gid] = cyc + L;
        end else if (!hz) begin
            m_valid = 0;
        end
        for (int i = 0; i < 4; i++) begin
            if (rb[i]) m_ready[i] = cyc + 1;
            if (sus[i]) m_susp[i] = 1;
            else if (res[i]) m_susp[i] = 0;
        end
        cyc++;
    endtask

    initial begin
        logic [3:0] e;
        model_reset();
        #1;
        check("reset_valid", ss_instruction_valid, 1'b0);
        check("reset_strand", ss_strand, 2'd0);
        check("reset_blocked", ss_strand_blocked, 4'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Round-robin from reset: 0,1,2,3,0.
        exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int n = 0; n < 5; n++) begin
            step(4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
            e = exp_q.pop_front();
            check("rr_grant", ss_strand_grant, e);
            if (n == 1) check("rr_valid_cycle2", ss_instruction_valid, 1'b1);
        end

        // Hazard hold for 3 cycles, then rotation resumes at strand 1.
        for (int n = 0; n < 3; n++) begin
            step(4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
            check("hz_grant", ss_strand_grant, 4'b0000);
            check("hz_strand", ss_strand, 2'd0);
        end
        step(4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        check("hz_resume", ss_strand_grant, 4'b0010);

        // Long latency on strand 1 alone: grants four cycles apart.
        step(4'b0010, 4'hF, 4'b0010, 4'h0, 4'h0, 4'h0, 1'b0);
        check("ll_first", ss_strand_grant, 4'b0010);
        for (int n = 0; n < 3; n++) begin
            step(4'b0010, 4'hF, 4'b0010, 4'h0, 4'h0, 4'h0, 1'b0);
            check("ll_gap_grant", ss_strand_grant, 4'b0000);
            check("ll_gap_blocked", ss_strand_blocked, 4'b0010);
        end
        step(4'b0010, 4'hF, 4'b0010, 4'h0, 4'h0, 4'h0, 1'b0);
        check("ll_second", ss_strand_grant, 4'b0010);

        // Suspend/resume with strands 0 and 2.
        step(4'b0101, 4'hF, 4'h0, 4'b0001, 4'h0, 4'h0, 1'b0);
        check("sus_grant_a", ss_strand_grant, 4'b0100);
        step(4'b0101, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        check("sus_grant_b", ss_strand_grant, 4'b0100);
        check("sus_blocked0", ss_strand_blocked[0], 1'b1);
        step(4'b0101, 4'hF, 4'h0, 4'b0001, 4'b0001, 4'h0, 1'b0);
        check("sus_both_grant", ss_strand_grant, 4'b0100);
        step(4'b0101, 4'hF, 4'h0, 4'h0, 4'b0001, 4'h0, 1'b0);
        check("sus_still_parked", ss_strand_grant, 4'b0100);
        step(4'b0101, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        check("resume_grant", ss_strand_grant, 4'b0001);

        // Rollback squashes a held strand-2 instruction despite the hazard.
        step(4'b0100, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        check("rb_setup", ss_strand_grant, 4'b0100);
        step(4'b0100, 4'hF, 4'h0, 4'h0, 4'h0, 4'b0100, 1'b1);
        check("rb_no_grant", ss_strand_grant, 4'b0000);
        step(4'b0000, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        check("rb_squashed", ss_instruction_valid, 1'b0);

        // Asynchronous reset between edges, mid-stream.
        step(4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0);
        step(4'hF, 4'hF, 4'hF, 4'b0010, 4'h0, 4'h0, 1'b0);
        #2;
        drive_idle();
        reset_n = 1'b0;
        #1;
        check("areset_valid", ss_instruction_valid, 1'b0);
        check("areset_strand", ss_strand, 2'd0);
        check("areset_blocked", ss_strand_blocked, 4'd0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        step(4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        check("areset_first", ss_strand_grant, 4'b0001);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] en, vld, ll, sus, res, rb;
            logic       hz;
            en  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
            vld = 4'($urandom) | 4'($urandom);
            ll  = 4'($urandom) & 4'($urandom);
            sus = 4'($urandom) & 4'($urandom) & 4'($urandom) & 4'($urandom);
            res = 4'($urandom) & 4'($urandom);
            rb  = 4'($urandom) & 4'($urandom) & 4'($urandom) & 4'($urandom);
            hz  = ($urandom_range(0, 4) == 0);
            step(en, vld, ll, sus, res, rb, hz);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
